// File: rtl/audio_mix_ctrl.sv
// Click-free sequencer for the mixer's att/mix controls: attenuation moves one
// level per step period on sample boundaries, and mix changes happen only at full mute.
module audio_mix_ctrl #(
  parameter int unsigned STEP_SAMPLES = 32,
  parameter logic [4:0]  RESET_ATT    = 5'h00,
  parameter logic [1:0]  RESET_MIX    = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_ce,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_att,
  input  logic [1:0] req_mix,
  output logic [4:0] att,
  output logic [1:0] mix,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RAMP     = 3'd1,
    S_FADE_OUT = 3'd2,
    S_SWITCH   = 3'd3,
    S_FADE_IN  = 3'd4
  } state_t;

  localparam logic [9:0] STEP_LAST = 10'(STEP_SAMPLES - 1);
  localparam logic [4:0] LVL_MUTE  = 5'd16;

  function automatic logic [4:0] att_to_lvl(input logic [4:0] a);
    if (a[4]) begin
      return LVL_MUTE;
    end else begin
      return {1'b0, a[3:0]};
    end
  endfunction

  function automatic logic [4:0] lvl_to_att(input logic [4:0] l);
    if (l >= LVL_MUTE) begin
      return 5'h10;
    end else begin
      return {1'b0, l[3:0]};
    end
  endfunction

  state_t     state_q, state_d;
  logic [4:0] att_q, att_d;
  logic [1:0] mix_q, mix_d;
  logic [4:0] tlvl_q, tlvl_d;
  logic [1:0] tmix_q, tmix_d;
  logic [9:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic [4:0] lvl_s, lvl_d;
  logic       tick_s;

  assign lvl_s  = att_to_lvl(att_q);
  assign tick_s = sample_ce && (cnt_q == STEP_LAST);
  assign att_d  = lvl_to_att(lvl_d);

  // State register and all sequencer registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      att_q   <= RESET_ATT;
      mix_q   <= RESET_MIX;
      tlvl_q  <= 5'd0;
      tmix_q  <= 2'd0;
      cnt_q   <= 10'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      att_q   <= att_d;
      mix_q   <= mix_d;
      tlvl_q  <= tlvl_d;
      tmix_q  <= tmix_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state, level stepping and step counter
  always_comb begin
    state_d = state_q;
    mix_d   = mix_q;
    tlvl_d  = tlvl_q;
    tmix_d  = tmix_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    lvl_d   = lvl_s;

    if ((state_q != S_IDLE) && sample_ce) begin
      cnt_d = tick_s ? 10'd0 : (cnt_q + 10'd1);
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = 10'd0;
        if (req_valid) begin
          tlvl_d  = att_to_lvl(req_att);
          tmix_d  = req_mix;
          state_d = (req_mix == mix_q) ? S_RAMP : S_FADE_OUT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RAMP: begin
        if (lvl_s == tlvl_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (tick_s) begin
          lvl_d = (lvl_s < tlvl_q) ? (lvl_s + 5'd1) : (lvl_s - 5'd1);
          if (lvl_d == tlvl_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RAMP;
          end
        end else begin
          state_d = S_RAMP;
        end
      end
      S_FADE_OUT: begin
        // The switch hold period is timed from a cleared counter
        if (lvl_s == LVL_MUTE) begin
          state_d = S_SWITCH;
          cnt_d   = 10'd0;
        end else if (tick_s) begin
          lvl_d = lvl_s + 5'd1;
          if (lvl_d == LVL_MUTE) begin
            state_d = S_SWITCH;
            cnt_d   = 10'd0;
          end else begin
            state_d = S_FADE_OUT;
          end
        end else begin
          state_d = S_FADE_OUT;
        end
      end
      S_SWITCH: begin
        mix_d = tmix_q;
        if (tick_s) begin
          if (tlvl_q == LVL_MUTE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FADE_IN;
          end
        end else begin
          state_d = S_SWITCH;
        end
      end
      S_FADE_IN: begin
        if (lvl_s == tlvl_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (tick_s) begin
          lvl_d = (lvl_s != 5'd0) ? (lvl_s - 5'd1) : lvl_s;
          if (lvl_d == tlvl_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FADE_IN;
          end
        end else begin
          state_d = S_FADE_IN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign att       = att_q;
  assign mix       = mix_q;

endmodule

// File: tb/tb_audio_mix_ctrl.sv
// Directed bench for audio_mix_ctrl with STEP_SAMPLES=4 and sample_ce every 8 clocks.
module tb_audio_mix_ctrl;

  typedef struct {
    logic [4:0] r_att;
    logic [1:0] r_mix;
    logic       intrude;
    logic [4:0] e_att;
    logic [1:0] e_mix;
    int         e_ce;
    int         e_chg;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_ce;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_att;
  logic [1:0] req_mix;
  logic [4:0] att;
  logic [1:0] mix;
  logic       busy;
  logic       done;

  int   checks = 0;
  int   errors = 0;
  int   ce_div = 0;
  logic last_ce = 1'b0;
  vec_t vecs[6];

  always #5 clk = ~clk;

  audio_mix_ctrl #(
    .STEP_SAMPLES(4),
    .RESET_ATT   (5'h00),
    .RESET_MIX   (2'd0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sample_ce(sample_ce),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_att  (req_att),
    .req_mix  (req_mix),
    .att      (att),
    .mix      (mix),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; remembers the sample_ce that the edge sampled, then drives the next one
  task automatic cyc();
    @(posedge clk);
    #1;
    last_ce   = sample_ce;
    ce_div    = (ce_div == 7) ? 0 : ce_div + 1;
    sample_ce = (ce_div == 7);
  endtask

  function automatic int lvl_of(input logic [4:0] a);
    return a[4] ? 16 : int'(a[3:0]);
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int         ce_cnt;
    int         chg;
    int         n;
    int         d;
    logic       got;
    logic [4:0] p_att;
    logic [1:0] p_mix;
    chk({tag, "_ready_idle"}, int'(req_ready), 1);
    req_valid = 1'b1;
    req_att   = v.r_att;
    req_mix   = v.r_mix;
    cyc();
    req_valid = 1'b0;
    chk({tag, "_busy_after_accept"}, int'(busy), 1);
    ce_cnt = 0;
    chg    = 0;
    n      = 0;
    got    = 1'b0;
    p_att  = att;
    p_mix  = mix;
    while (!got && n < 2000) begin
      if (v.intrude && n == 20) begin
        req_valid = 1'b1;
        req_att   = 5'd9;
        req_mix   = 2'd0;
      end
      if (v.intrude && n == 26) req_valid = 1'b0;
      cyc();
      n++;
      if (v.intrude && n == 21) chk({tag, "_ready_while_busy"}, int'(req_ready), 0);
      if (last_ce) ce_cnt++;
      if (att != p_att) begin
        chg++;
        d = lvl_of(att) - lvl_of(p_att);
        chk({tag, "_step_size"}, (d < 0) ? -d : d, 1);
        chk({tag, "_step_on_sample"}, int'(last_ce), 1);
      end
      if (mix != p_mix) begin
        chk({tag, "_mix_at_mute"}, int'(p_att == 5'h10 && att == 5'h10), 1);
      end
      p_att = att;
      p_mix = mix;
      if (done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, int'(got), 1);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    if (v.e_ce >= 0) chk({tag, "_samples_to_done"}, ce_cnt, v.e_ce);
    chk({tag, "_att_changes"}, chg, v.e_chg);
    chk({tag, "_final_att"}, int'(att), int'(v.e_att));
    chk({tag, "_final_mix"}, int'(mix), int'(v.e_mix));
  endtask

  initial begin
    vec_t pr;
    int   n;
    // {req_att, req_mix, intrude, exp att, exp mix, counted sample_ce to done, att changes}
    vecs[0] = '{5'h03, 2'd0, 1'b0, 5'h03, 2'd0, 12, 3};
    vecs[1] = '{5'h02, 2'd2, 1'b1, 5'h02, 2'd2, 112, 27};
    vecs[2] = '{5'h15, 2'd1, 1'b0, 5'h10, 2'd1, 60, 14};
    vecs[3] = '{5'h1F, 2'd1, 1'b0, 5'h10, 2'd1, -1, 0};
    vecs[4] = '{5'h0D, 2'd1, 1'b0, 5'h0D, 2'd1, 12, 3};
    vecs[5] = '{5'h00, 2'd1, 1'b0, 5'h00, 2'd1, 52, 13};

    reset     = 1'b1;
    sample_ce = 1'b0;
    req_valid = 1'b0;
    req_att   = 5'h00;
    req_mix   = 2'd0;
    repeat (3) cyc();
    chk("reset_att", int'(att), 0);
    chk("reset_mix", int'(mix), 0);
    chk("reset_ready", int'(req_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a fade-out
    req_valid = 1'b1;
    req_att   = 5'h00;
    req_mix   = 2'd3;
    cyc();
    req_valid = 1'b0;
    n = 0;
    while (att != 5'h07 && n < 1000) begin
      cyc();
      n++;
    end
    chk("fo_reached_att7", int'(att), 7);
    chk("fo_busy", int'(busy), 1);
    chk("fo_mix_held", int'(mix), 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midreset_att", int'(att), 0);
    chk("midreset_mix", int'(mix), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    chk("midreset_ready", int'(req_ready), 1);
    pr = '{5'h02, 2'd0, 1'b0, 5'h02, 2'd0, 8, 2};
    run_vec(pr, "post_reset");
    cyc();
    chk("done_one_cycle", int'(done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
